// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM: config register map, mode encodings
// and counter direction.
package pwm_pkg;

    localparam int unsigned ADDR_PERIOD    = 0;
    localparam int unsigned ADDR_MODE      = 1;
    localparam int unsigned ADDR_DUTY_BASE = 2;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair and the registered comparator against the
// shared period counter.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_data_i,
    input  logic             load_imm_i,
    input  logic             load_bnd_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             pwm_o
);

    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        duty_sh_d  = wr_i ? wr_data_i : duty_sh_q;
        duty_act_d = duty_act_q;
        // While idle the active copy follows the write in flight; at a boundary it
        // takes the already-settled shadow so a coincident write waits a period.
        if (load_imm_i) begin
            duty_act_d = duty_sh_d;
        end else if (load_bnd_i) begin
            duty_act_d = duty_sh_q;
        end
        pwm_d = en_i && (cnt_i < duty_act_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared edge/center-aligned period counter and
// shadowed configuration that is committed only at period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned DEFAULT_PERIOD = 100,
    parameter int unsigned ADDR_W         = $clog2(CHANNELS + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [CNT_W-1:0]    cfg_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic [CNT_W-1:0] period_sh_q, period_sh_d;
    logic [CNT_W-1:0] period_act_q, period_act_d;
    logic             mode_sh_q, mode_sh_d;
    logic             mode_act_q, mode_act_d;
    logic             period_start_q, period_start_d;

    logic [CNT_W-1:0] cnt_max;
    logic             wr_period, wr_mode;
    logic             load_imm, load_bnd;
    logic             boundary_now;

    assign wr_period = cfg_we && (cfg_addr == ADDR_W'(ADDR_PERIOD));
    assign wr_mode   = cfg_we && (cfg_addr == ADDR_W'(ADDR_MODE));

    // A programmed period of 0 behaves as 1.
    assign cnt_max = (period_act_q == '0) ? '0 : period_act_q - CNT_W'(1);

    assign boundary_now = (cnt_q == '0) && ((mode_act_q == MODE_EDGE) || (dir_q == DirUp));

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!en) begin
            cnt_d = '0;
            dir_d = DirUp;
        end else if (mode_act_q == MODE_EDGE) begin
            cnt_d = (cnt_q >= cnt_max) ? '0 : cnt_q + CNT_W'(1);
            dir_d = DirUp;
        end else if (dir_q == DirUp) begin
            if (cnt_q >= cnt_max) begin
                dir_d = DirDown;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            if (cnt_q == '0) begin
                dir_d = DirUp;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        load_imm = !en;
        load_bnd = en && (cnt_d == '0) && ((mode_act_q == MODE_EDGE) || (dir_d == DirUp));
        if (load_bnd) begin
            dir_d = DirUp;
        end

        period_sh_d  = wr_period ? cfg_data : period_sh_q;
        mode_sh_d    = wr_mode ? cfg_data[0] : mode_sh_q;
        period_act_d = period_act_q;
        mode_act_d   = mode_act_q;
        if (load_imm) begin
            period_act_d = period_sh_d;
            mode_act_d   = mode_sh_d;
        end else if (load_bnd) begin
            period_act_d = period_sh_q;
            mode_act_d   = mode_sh_q;
        end

        period_start_d = en && boundary_now;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            dir_q          <= DirUp;
            period_sh_q    <= CNT_W'(DEFAULT_PERIOD);
            period_act_q   <= CNT_W'(DEFAULT_PERIOD);
            mode_sh_q      <= MODE_EDGE;
            mode_act_q     <= MODE_EDGE;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            period_sh_q    <= period_sh_d;
            period_act_q   <= period_act_d;
            mode_sh_q      <= mode_sh_d;
            mode_act_q     <= mode_act_d;
            period_start_q <= period_start_d;
        end
    end

    assign period_start = period_start_q;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        localparam logic [ADDR_W-1:0] ChAddr = ADDR_W'(ADDR_DUTY_BASE + gi);

        pwm_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .en_i      (en),
            .wr_i      (cfg_we && (cfg_addr == ChAddr)),
            .wr_data_i (cfg_data),
            .load_imm_i(load_imm),
            .load_bnd_i(load_bnd),
            .cnt_i     (cnt_q),
            .pwm_o     (pwm_out[gi])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi: reset defaults, edge and center
// modes, shadowed updates, period changes and asynchronous reset.
module tb_pwm_multi;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned ADDR_W   = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                cfg_we;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [CNT_W-1:0]    cfg_data;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_start;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pwm_multi #(
        .CHANNELS      (CHANNELS),
        .CNT_W         (CNT_W),
        .DEFAULT_PERIOD(100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input logic we, input int unsigned addr, input int unsigned data);
        cfg_we   = we;
        cfg_addr = ADDR_W'(addr);
        cfg_data = CNT_W'(data);
    endtask

    task automatic cfg_write(input int unsigned addr, input int unsigned data);
        drive_cfg(1'b1, addr, data);
        step();
        drive_cfg(1'b0, 0, 0);
    endtask

    initial begin
        int          ph;
        int          dty;
        int          cv;
        logic [3:0]  e;

        rst = 1'b1;
        en  = 1'b0;
        drive_cfg(1'b0, 0, 0);
        step();
        step();
        check_eq("rst_pwm", 32'(pwm_out), 32'h0);
        check_eq("rst_ps", 32'(period_start), 32'h0);
        rst = 1'b0;
        step();

        // Defaults: period 100, all duties 0.
        for (int k = 0; k < 250; k++) begin
            en = 1'b1;
            step();
            check_eq("def_ps", 32'(period_start), 32'((k % 100) == 0));
            check_eq("def_pwm", 32'(pwm_out), 32'h0);
        end
        en = 1'b0;
        step();
        step();
        check_eq("en_low_pwm", 32'(pwm_out), 32'h0);
        check_eq("en_low_ps", 32'(period_start), 32'h0);

        // Edge mode, P=10, duties 7/0/10/3.
        cfg_write(0, 10);
        cfg_write(1, 0);
        cfg_write(2, 7);
        cfg_write(3, 0);
        cfg_write(4, 10);
        cfg_write(5, 3);
        for (int k = 0; k < 30; k++) begin
            en = 1'b1;
            step();
            ph   = k % 10;
            e[0] = (ph < 7);
            e[1] = 1'b0;
            e[2] = 1'b1;
            e[3] = (ph < 3);
            check_eq("edge_pwm", 32'(pwm_out), 32'(e));
            check_eq("edge_ps", 32'(period_start), 32'(ph == 0));
        end

        // Center mode, P=10, DUTY0=3.
        en = 1'b0;
        step();
        cfg_write(1, 1);
        cfg_write(2, 3);
        for (int k = 0; k < 45; k++) begin
            en = 1'b1;
            step();
            ph   = k % 20;
            cv   = (ph < 10) ? ph : 19 - ph;
            e[0] = (cv < 3);
            e[1] = 1'b0;
            e[2] = 1'b1;
            e[3] = (cv < 3);
            check_eq("ctr_pwm", 32'(pwm_out), 32'(e));
            check_eq("ctr_ps", 32'(period_start), 32'(ph == 0));
        end

        // Mid-period and boundary-coincident duty writes.
        en = 1'b0;
        step();
        cfg_write(1, 0);
        cfg_write(2, 2);
        for (int k = 0; k < 40; k++) begin
            en = 1'b1;
            if (k == 4) drive_cfg(1'b1, 2, 8);
            else if (k == 20) drive_cfg(1'b1, 2, 5);
            else drive_cfg(1'b0, 0, 0);
            step();
            ph  = k % 10;
            dty = (k < 10) ? 2 : (k < 30) ? 8 : 5;
            check_eq("upd_ch0", 32'(pwm_out[0]), 32'(ph < dty));
            check_eq("upd_ps", 32'(period_start), 32'(ph == 0));
        end
        drive_cfg(1'b0, 0, 0);

        // Period 10 -> 5 at cnt=6, then 5 -> 0 on a boundary cycle.
        en = 1'b0;
        step();
        cfg_write(2, 3);
        for (int k = 0; k < 45; k++) begin
            en = 1'b1;
            if (k == 6) drive_cfg(1'b1, 0, 5);
            else if (k == 30) drive_cfg(1'b1, 0, 0);
            else drive_cfg(1'b0, 0, 0);
            step();
            if (k < 10) ph = k;
            else if (k < 35) ph = (k - 10) % 5;
            else ph = 0;
            check_eq("per_ch0", 32'(pwm_out[0]), 32'(ph < 3));
            check_eq("per_ps", 32'(period_start), 32'(ph == 0));
        end
        drive_cfg(1'b0, 0, 0);

        // Asynchronous reset at cnt=5 with DUTY0=8.
        en = 1'b0;
        step();
        cfg_write(0, 10);
        cfg_write(2, 8);
        for (int k = 0; k < 5; k++) begin
            en = 1'b1;
            step();
            check_eq("pre_rst_ch0", 32'(pwm_out[0]), 32'h1);
            check_eq("pre_rst_ps", 32'(period_start), 32'(k == 0));
        end
        rst = 1'b1;
        #2;
        check_eq("async_rst_pwm", 32'(pwm_out), 32'h0);
        check_eq("async_rst_ps", 32'(period_start), 32'h0);
        en = 1'b0;
        step();
        step();
        rst = 1'b0;
        cfg_write(7, 16'hFFFF);
        for (int k = 0; k < 210; k++) begin
            en = 1'b1;
            if (k == 3) drive_cfg(1'b1, 7, 16'hFFFF);
            else drive_cfg(1'b0, 0, 0);
            step();
            check_eq("post_rst_ps", 32'(period_start), 32'((k % 100) == 0));
            check_eq("post_rst_pwm", 32'(pwm_out), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
